// File: rtl/uart_tx_scheduler_if.sv
// Request/UART handshake bundle for uart_tx_scheduler.
// master = scheduler side, slave = requesters plus UART.
interface uart_tx_scheduler_if #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned MAX_BYTES = 4
);
    localparam int unsigned LEN_W = 3;
    localparam int unsigned MSG_W = 8 * MAX_BYTES;

    logic [N_REQ-1:0]       req_valid;
    logic [LEN_W*N_REQ-1:0] req_len;
    logic [MSG_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]       req_gnt;
    logic [N_REQ-1:0]       req_done;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy;

    modport master (
        input  req_valid, req_len, req_data, tx_busy,
        output req_gnt, req_done, tx_data, tx_start
    );

    modport slave (
        output req_valid, req_len, req_data, tx_busy,
        input  req_gnt, req_done, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ message
// sources, serialising each granted 1..MAX_BYTES message MSB byte first.
module uart_tx_scheduler #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_scheduler_if.master  bus,
    output logic                 sched_busy,
    output logic [2:0]           grant_id,
    output logic [15:0]          frames_sent
);
    localparam int unsigned MSG_W = 8 * MAX_BYTES;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_DRAIN} state_t;

    state_t           state;
    logic [ID_W-1:0]  last;
    logic [MSG_W-1:0] shift;
    logic [CNT_W-1:0] remaining;

    logic             pick_valid;
    logic [ID_W-1:0]  pick;
    logic [MSG_W-1:0] pick_data;
    logic [LEN_W-1:0] pick_len;
    logic [CNT_W-1:0] pick_cnt;
    int               idx;

    // Round-robin pick: scan last+1 .. last+N_REQ; nearest pending requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_data  = '0;
        pick_len   = '0;
        idx        = 0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (i == idx && bus.req_valid[i]) begin
                    pick_valid = 1'b1;
                    pick       = ID_W'(i);
                    pick_data  = bus.req_data[i*MSG_W +: MSG_W];
                    pick_len   = bus.req_len[i*LEN_W +: LEN_W];
                end
            end
        end
        if (int'(pick_len) > int'(MAX_BYTES)) pick_cnt = CNT_W'(MAX_BYTES);
        else                                  pick_cnt = CNT_W'(pick_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last         <= ID_W'(N_REQ - 1);
            shift        <= '0;
            remaining    <= '0;
            bus.req_gnt  <= '0;
            bus.req_done <= '0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
            sched_busy   <= 1'b0;
            grant_id     <= '0;
            frames_sent  <= '0;
        end else begin
            bus.req_gnt  <= '0;
            bus.req_done <= '0;
            bus.tx_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        bus.req_gnt <= N_REQ'(1) << pick;
                        grant_id    <= pick;
                        last        <= pick;
                        shift       <= pick_data;
                        remaining   <= pick_cnt;
                        sched_busy  <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Only a zero-length message reaches LOAD with nothing left.
                    if (remaining == '0) begin
                        bus.req_done <= N_REQ'(1) << grant_id;
                        sched_busy   <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        bus.tx_data  <= shift[MSG_W-1 -: 8];
                        bus.tx_start <= 1'b1;
                        shift        <= shift << 8;
                        remaining    <= remaining - CNT_W'(1);
                        state        <= S_ACK;
                    end
                end
                S_ACK: begin
                    // UART busy is not yet visible here.
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (remaining != '0) begin
                            state <= S_LOAD;
                        end else begin
                            bus.req_done <= N_REQ'(1) << grant_id;
                            frames_sent  <= frames_sent + 16'd1;
                            sched_busy   <= 1'b0;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural UART busy model
// and auto-dropping requesters.
module tb_uart_tx_scheduler;
    localparam int unsigned N_REQ     = 3;
    localparam int unsigned MAX_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_busy;
    logic [2:0]  grant_id;
    logic [15:0] frames_sent;

    uart_tx_scheduler_if #(.N_REQ(N_REQ), .MAX_BYTES(MAX_BYTES)) bus ();

    uart_tx_scheduler #(.N_REQ(N_REQ), .MAX_BYTES(MAX_BYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sched_busy  (sched_busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_len = 20;
    int bcnt     = 0;
    int proto_err = 0;
    int done_cnt  = 0;
    logic prev_start = 1'b0;
    int obs_q[$];
    int tx_cyc[$];
    int log_id[$];
    int log_cyc[$];
    int exp_q[$];
    int rearm_left [N_REQ];

    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy rises the cycle after tx_start and stays high busy_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            bcnt        <= 0;
        end else if (bus.tx_start) begin
            bus.tx_busy <= 1'b1;
            bcnt        <= busy_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt        <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    // Monitor: logs bytes, grants (id) and completions (100+id) with cycle stamps.
    always @(posedge clk) begin
        #1;
        if (bus.tx_start === 1'b1) begin
            if (bus.tx_busy === 1'b1 || prev_start) proto_err++;
            obs_q.push_back(int'(bus.tx_data));
            tx_cyc.push_back(cyc);
        end
        prev_start = (bus.tx_start === 1'b1);
        if (!$onehot0(bus.req_gnt) || !$onehot0(bus.req_done)) proto_err++;
        for (int i = 0; i < int'(N_REQ); i++)
            if (bus.req_gnt[i] === 1'b1) begin
                log_id.push_back(i);
                log_cyc.push_back(cyc);
            end
        for (int i = 0; i < int'(N_REQ); i++)
            if (bus.req_done[i] === 1'b1) begin
                log_id.push_back(100 + i);
                log_cyc.push_back(cyc);
                done_cnt++;
            end
    end

    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < int'(N_REQ); i++)
            if (bus.req_gnt[i] === 1'b1) begin
                if (rearm_left[i] > 0) rearm_left[i]--;
                else                   bus.req_valid[i] = 1'b0;
            end
    endtask

    task automatic set_req(input int i, input logic [2:0] len, input logic [31:0] data);
        bus.req_len[3*i +: 3]   = len;
        bus.req_data[32*i +: 32] = data;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < int'(N_REQ); i++) rearm_left[i] = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_len   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) rearm_left[i] = 0;
        step();
        step();
        n_checks++; if (bus.req_gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", bus.req_gnt); end
        n_checks++; if (bus.req_done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b want 000", bus.req_done); end
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", sched_busy); end
        n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        rst = 1'b0;
        repeat (4) step();
        n_checks++; if (sched_busy !== 1'b0 || bus.req_gnt !== 3'b000 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL idle_hold: busy %b gnt %b bytes %0d want 0/000/0", sched_busy, bus.req_gnt, obs_q.size());
        end
    endtask

    task automatic test_single();
        int c, ob, lb, e;
        bit ok;
        apply_reset();
        busy_len = 20;
        ob = obs_q.size(); lb = log_id.size();
        set_req(1, 3'd2, 32'hA1B2_C3D4);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        c = cyc;
        bus.req_valid[1] = 1'b1;
        run_until_done(done_cnt + 1, 200, ok);
        repeat (3) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no req_done within 200 cycles"); end
        n_checks++;
        if (log_id.size() != lb + 2) begin
            n_fail++; $display("FAIL single_events: got %0d events want 2", log_id.size() - lb);
        end else if (log_id[lb] != 1 || log_id[lb+1] != 101 || log_cyc[lb] != c + 1) begin
            n_fail++; $display("FAIL single_seq: got %0d@%0d,%0d want 1@%0d,101", log_id[lb], log_cyc[lb], log_id[lb+1], c + 1);
        end
        n_checks++;
        if (tx_cyc.size() <= ob || tx_cyc[ob] != c + 2) begin
            n_fail++; $display("FAIL single_first_start: got cycle %0d want %0d", (tx_cyc.size() > ob) ? tx_cyc[ob] : -1, c + 2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob >= obs_q.size()) begin n_fail++; $display("FAIL single_byte: missing, want %02h", e); end
            else begin
                if (obs_q[ob] != e) begin n_fail++; $display("FAIL single_byte: got %02h want %02h", obs_q[ob], e); end
                ob++;
            end
        end
        n_checks++; if (ob != obs_q.size()) begin n_fail++; $display("FAIL single_extra: got %0d bytes want %0d", obs_q.size(), ob); end
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL single_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_round_robin();
        int ob, lb, e;
        int exp_log [6] = '{0, 100, 1, 101, 2, 102};
        bit ok;
        apply_reset();
        busy_len = 5;
        ob = obs_q.size(); lb = log_id.size();
        set_req(0, 3'd1, 32'hA011_1111);
        set_req(1, 3'd1, 32'hB022_2222);
        set_req(2, 3'd1, 32'hC033_3333);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hB0); exp_q.push_back(8'hC0);
        bus.req_valid = 3'b111;
        run_until_done(done_cnt + 3, 300, ok);
        repeat (3) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: fewer than 3 req_done in 300 cycles"); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (lb + i >= log_id.size()) begin n_fail++; $display("FAIL rr_order[%0d]: missing want %0d", i, exp_log[i]); end
            else if (log_id[lb+i] != exp_log[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, log_id[lb+i], exp_log[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob >= obs_q.size()) begin n_fail++; $display("FAIL rr_byte: missing, want %02h", e); end
            else begin
                if (obs_q[ob] != e) begin n_fail++; $display("FAIL rr_byte: got %02h want %02h", obs_q[ob], e); end
                ob++;
            end
        end
        n_checks++; if (frames_sent !== 16'd3) begin n_fail++; $display("FAIL rr_frames: got %0d want 3", frames_sent); end
    endtask

    task automatic test_back_to_back();
        int ob, lb, e;
        bit ok;
        apply_reset();
        busy_len = 4;
        ob = obs_q.size(); lb = log_id.size();
        set_req(0, 3'd1, 32'h0A00_0000);
        set_req(2, 3'd1, 32'h2C00_0000);
        rearm_left[0] = 2;
        rearm_left[2] = 2;
        repeat (3) begin exp_q.push_back(8'h0A); exp_q.push_back(8'h2C); end
        bus.req_valid = 3'b101;
        run_until_done(done_cnt + 6, 600, ok);
        repeat (3) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: fewer than 6 req_done in 600 cycles"); end
        for (int i = 0; i < 12; i++) begin
            int want;
            want = ((i / 2) % 2 == 0 ? 0 : 2) + ((i % 2 == 1) ? 100 : 0);
            n_checks++;
            if (lb + i >= log_id.size()) begin n_fail++; $display("FAIL b2b_order[%0d]: missing want %0d", i, want); end
            else if (log_id[lb+i] != want) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, log_id[lb+i], want); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob >= obs_q.size()) begin n_fail++; $display("FAIL b2b_byte: missing, want %02h", e); end
            else begin
                if (obs_q[ob] != e) begin n_fail++; $display("FAIL b2b_byte: got %02h want %02h", obs_q[ob], e); end
                ob++;
            end
        end
        n_checks++; if (frames_sent !== 16'd6) begin n_fail++; $display("FAIL b2b_frames: got %0d want 6", frames_sent); end
        n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL b2b_protocol: got %0d violations want 0", proto_err); end
    endtask

    task automatic test_len_zero();
        int c, ob, lb;
        bit ok;
        apply_reset();
        ob = obs_q.size(); lb = log_id.size();
        set_req(2, 3'd0, 32'hDEAD_BEEF);
        c = cyc;
        bus.req_valid[2] = 1'b1;
        run_until_done(done_cnt + 1, 20, ok);
        repeat (4) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL len0_timeout: no req_done within 20 cycles"); end
        n_checks++;
        if (log_id.size() != lb + 2) begin
            n_fail++; $display("FAIL len0_events: got %0d events want 2", log_id.size() - lb);
        end else if (log_id[lb] != 2 || log_cyc[lb] != c + 1 || log_id[lb+1] != 102 || log_cyc[lb+1] != c + 2) begin
            n_fail++; $display("FAIL len0_seq: got %0d@%0d %0d@%0d want 2@%0d 102@%0d",
                               log_id[lb], log_cyc[lb], log_id[lb+1], log_cyc[lb+1], c + 1, c + 2);
        end
        n_checks++; if (obs_q.size() != ob) begin n_fail++; $display("FAIL len0_tx: got %0d tx_start want 0", obs_q.size() - ob); end
        n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL len0_frames: got %0d want 0", frames_sent); end
    endtask

    task automatic test_clamp();
        int ob, lb, e;
        bit ok;
        apply_reset();
        busy_len = 3;
        ob = obs_q.size(); lb = log_id.size();
        set_req(0, 3'd7, 32'h1122_3344);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        bus.req_valid[0] = 1'b1;
        run_until_done(done_cnt + 1, 200, ok);
        repeat (6) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_timeout: no req_done within 200 cycles"); end
        n_checks++; if (log_id.size() != lb + 2) begin n_fail++; $display("FAIL clamp_events: got %0d events want 2", log_id.size() - lb); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob >= obs_q.size()) begin n_fail++; $display("FAIL clamp_byte: missing, want %02h", e); end
            else begin
                if (obs_q[ob] != e) begin n_fail++; $display("FAIL clamp_byte: got %02h want %02h", obs_q[ob], e); end
                ob++;
            end
        end
        n_checks++; if (ob != obs_q.size()) begin n_fail++; $display("FAIL clamp_extra: got %0d bytes want %0d", obs_q.size(), ob); end
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL clamp_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_reset_mid();
        int ob, lb, dn, e;
        int exp_log [4] = '{0, 100, 1, 101};
        bit ok;
        apply_reset();
        busy_len = 20;
        ob = obs_q.size();
        dn = done_cnt;
        set_req(1, 3'd3, 32'h5566_7788);
        exp_q.push_back(8'h55);
        bus.req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (obs_q.size() > ob && bus.tx_busy === 1'b1) begin ok = 1'b1; break; end
        end
        repeat (3) step();
        n_checks++; if (!ok || sched_busy !== 1'b1) begin n_fail++; $display("FAIL mid_drain: reached %b busy %b want 1/1", ok, sched_busy); end
        rst = 1'b1;
        step();
        n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", sched_busy); end
        n_checks++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx: got %b/%h want 0/00", bus.tx_start, bus.tx_data); end
        n_checks++; if (bus.req_gnt !== 3'b000 || bus.req_done !== 3'b000) begin n_fail++; $display("FAIL mid_pulses: got %b/%b want 000/000", bus.req_gnt, bus.req_done); end
        n_checks++; if (grant_id !== 3'd0 || frames_sent !== 16'd0) begin n_fail++; $display("FAIL mid_regs: got %0d/%0d want 0/0", grant_id, frames_sent); end
        rst = 1'b0;
        repeat (5) step();
        n_checks++; if (done_cnt != dn) begin n_fail++; $display("FAIL mid_no_done: got %0d req_done want 0", done_cnt - dn); end
        lb = log_id.size();
        set_req(0, 3'd1, 32'h0100_0000);
        set_req(1, 3'd1, 32'h0200_0000);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        bus.req_valid = 3'b011;
        run_until_done(done_cnt + 2, 200, ok);
        repeat (3) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_fresh_timeout: fewer than 2 req_done in 200 cycles"); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (lb + i >= log_id.size()) begin n_fail++; $display("FAIL mid_order[%0d]: missing want %0d", i, exp_log[i]); end
            else if (log_id[lb+i] != exp_log[i]) begin n_fail++; $display("FAIL mid_order[%0d]: got %0d want %0d", i, log_id[lb+i], exp_log[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob >= obs_q.size()) begin n_fail++; $display("FAIL mid_byte: missing, want %02h", e); end
            else begin
                if (obs_q[ob] != e) begin n_fail++; $display("FAIL mid_byte: got %02h want %02h", obs_q[ob], e); end
                ob++;
            end
        end
        n_checks++; if (frames_sent !== 16'd2) begin n_fail++; $display("FAIL mid_frames: got %0d want 2", frames_sent); end
        n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL mid_protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_len_zero();
        test_clamp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter among N_REQ response sources: trade action/RSI frames, status/heartbeat frames and error frames.
- Each source presents a complete message of 1–4 bytes; the scheduler grants round-robin, latches the message and serialises it byte-by-byte through the tx_data/tx_start/tx_busy handshake.
- Sits between the response producers and uart_txrx inside hft_accelerator, replacing the ad-hoc per-source TX state machines.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_BYTES, 4, maximum message length in bytes; message word is 8*MAX_BYTES bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  N_REQ  per-requester message pending; held until req_gnt
- req_len  input  3*N_REQ  per-requester byte count, slice i = [3i+2:3i]
- req_data  input  32*N_REQ  per-requester message, slice i = [32i+31:32i]; byte [31:24] sent first
- req_gnt  output  N_REQ  one-cycle one-hot pulse: message captured
- req_done  output  N_REQ  one-cycle one-hot pulse: last byte fully shifted out
- tx_data  output  8  byte to UART
- tx_start  output  1  one-cycle pulse launching tx_data
- tx_busy  input  1  UART busy; rises the cycle after tx_start, falls after stop bit
- sched_busy  output  1  high in any state other than IDLE
- grant_id  output  3  index of requester currently or last served
- frames_sent  output  16  count of completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: state IDLE; req_gnt=0, req_done=0, tx_start=0, tx_data=0, sched_busy=0, grant_id=0, frames_sent=0; rr pointer last=N_REQ-1 so requester 0 wins first.
- Reset mid-frame: abandons the frame immediately; no req_done; tx_start low the cycle after reset.
- States: IDLE, LOAD, ACK, DRAIN.
- IDLE: if any req_valid, select the first set bit scanning last+1, last+2 ... modulo N_REQ.
  - Registered outputs: req_gnt[w]=1, grant_id=w, last=w.
  - Latch data_w and len_w into shift reg and remaining count; -> LOAD.
- Length rules:
  - len>MAX_BYTES clamps to MAX_BYTES.
  - len=0 -> no UART activity; req_done[w] pulses the cycle after req_gnt; frames_sent unchanged; -> IDLE.
- LOAD: tx_data=shift[31:24], tx_start=1, shift<<=8, remaining-=1; -> ACK.
- ACK: tx_start=0; -> DRAIN. tx_busy is not evaluated in this cycle.
- DRAIN: wait while tx_busy=1. On tx_busy=0:
  - If remaining>0 -> LOAD.
  - Else pulse req_done[w], increment frames_sent, -> IDLE.
- Latency:
  - req_valid sampled at edge E0 -> req_gnt high after E0.
  - First tx_start high after E1.
  - Inter-byte gap is one idle cycle after tx_busy falls.
- req_data and req_len are sampled only on the grant edge; later changes do not affect the frame in flight.
- A requester may raise req_valid again right after its req_gnt.
  - It is not re-granted before req_done.
  - Another pending requester always wins next (no starvation).
- req_valid on a requester while it is being served has no effect until IDLE.
- IDLE with no requests: all outputs held, no pulses.
- tx_start never asserts while tx_busy=1 or in two consecutive cycles.

Test Plan:
- Single requester 1, len=2, data=0xA1B2_xxxx, UART busy 20 cycles/byte -> req_gnt[1] one cycle after req_valid; bytes 0xA1 then 0xB2; req_done[1] once after second busy falls; frames_sent=1.
- req_valid=3'b111 simultaneously, len=1 each -> grants in order 0,1,2; each req_done precedes the next req_gnt; frames_sent=3.
- Requester 0 re-asserts immediately after every grant while 2 is pending -> order 0,2,0,2..., requester 2 never skipped.
- len=0 on requester 2 -> req_gnt[2] then req_done[2] next cycle; tx_start stays 0; frames_sent unchanged.
- len=7, data=0x11223344 -> exactly 4 bytes 0x11,0x22,0x33,0x44; single req_done.
- rst asserted in DRAIN after byte 1 of 3 -> next cycle IDLE, outputs at reset values, no req_done; a fresh request afterwards is granted to requester 0 first.
